// File: rtl/prog_loader_if.sv
// Serial host link and program-memory write port of the program loader.
// The loader takes the slave view; the host/bench takes the master view.
interface prog_loader_if;
    logic        ld_sck;
    logic        ld_sdi;
    logic        ld_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        err;
    logic [11:0] wr_count;

    modport master (
        output ld_sck, ld_sdi, ld_en,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, err, wr_count
    );

    modport slave (
        input  ld_sck, ld_sdi, ld_en,
        output mem_we, mem_addr, mem_wdata, cpu_hold, busy, err, wr_count
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: receives a 12-bit start address and program bytes over
// a 3-wire link and writes them sequentially into the 4096 x 8 program memory.
module prog_loader #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    prog_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic en_prev_q, en_prev_d;
    logic sdi_q, sdi_d;
    logic sck_rise_q, sck_rise_d;
    logic en_rise_q, en_rise_d;
    logic en_fall_q, en_fall_d;
    logic [2:0] blank_q, blank_d;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [11:0] addr_q, addr_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;
    logic [11:0] wr_count_q, wr_count_d;

    logic       sck_s, en_s, armed, byte_rdy;
    logic [7:0] byte_val;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign en_s  = en_sync_q[SYNC_STAGES-1];
    assign armed = (blank_q == 3'd0);

    // Edge pulses are suppressed until the cleared synchronizers have refilled
    // after reset, so a host still holding ld_en high does not look like a new session.
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.ld_sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.ld_sdi};
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], bus.ld_en};
        sck_prev_d = sck_s;
        en_prev_d  = en_s;
        sdi_d      = sdi_sync_q[SYNC_STAGES-1];
        sck_rise_d = armed && sck_s && !sck_prev_q && en_s;
        en_rise_d  = armed && en_s && !en_prev_q;
        en_fall_d  = armed && !en_s && en_prev_q;
        blank_d    = armed ? 3'd0 : blank_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            en_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            en_prev_q  <= 1'b0;
            sdi_q      <= 1'b0;
            sck_rise_q <= 1'b0;
            en_rise_q  <= 1'b0;
            en_fall_q  <= 1'b0;
            blank_q    <= 3'(SYNC_STAGES + 1);
        end else begin
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            en_sync_q  <= en_sync_d;
            sck_prev_q <= sck_prev_d;
            en_prev_q  <= en_prev_d;
            sdi_q      <= sdi_d;
            sck_rise_q <= sck_rise_d;
            en_rise_q  <= en_rise_d;
            en_fall_q  <= en_fall_d;
            blank_q    <= blank_d;
        end
    end

    assign byte_val = {shift_q, sdi_q};
    assign byte_rdy = sck_rise_q && (state_q != IDLE) && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        wr_count_d  = wr_count_q;

        if (mem_we_q) begin
            addr_d     = addr_q + 12'd1;
            wr_count_d = wr_count_q + 12'd1;
        end

        if (sck_rise_q && (state_q != IDLE)) begin
            shift_d   = byte_val[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (en_rise_q) begin
                    state_d    = ADDR_HI;
                    bit_cnt_d  = 3'd0;
                    wr_count_d = '0;
                    err_d      = 1'b0;
                end
            end
            ADDR_HI: begin
                if (byte_rdy) begin
                    addr_d[11:8] = byte_val[3:0];
                    state_d      = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (byte_rdy) begin
                    addr_d[7:0] = byte_val;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (byte_rdy) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = byte_val;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte completing in the same cycle leaves the counter at zero, so err stays clear.
        if ((state_q != IDLE) && en_fall_q) begin
            state_d   = IDLE;
            err_d     = (bit_cnt_d != 3'd0);
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            wr_count_q  <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.cpu_hold  = (state_q != IDLE) || mem_we_q;
    assign bus.err       = err_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed serial sessions push expected
// memory writes; a monitor pops and compares on every mem_we.
module tb_prog_loader;

    logic clk;
    logic rst;
    logic ena;
    int   checks;
    int   failures;
    logic [19:0] exp_q[$];

    prog_loader_if bus();

    prog_loader #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // MSB first; high and low phases of 4 clk each.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.ld_sdi = v[i];
            tick(4);
            bus.ld_sck = 1'b1;
            tick(4);
            bus.ld_sck = 1'b0;
        end
    endtask

    task automatic expect_write(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic open_session();
        bus.ld_en = 1'b1;
        tick(6);
    endtask

    task automatic close_session();
        tick(4);
        bus.ld_en = 1'b0;
        tick(8);
    endtask

    // Monitor: every ena-qualified write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst && ena && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                check("write", {12'h0, bus.mem_addr, bus.mem_wdata}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish required finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        ena        = 1'b1;
        bus.ld_sck = 1'b0;
        bus.ld_sdi = 1'b0;
        bus.ld_en  = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 12'h000);
        check("rst_mem_wdata", bus.mem_wdata, 8'h00);
        check("rst_cpu_hold", bus.cpu_hold, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_wr_count", bus.wr_count, 12'h000);
        tick(6);

        // Basic load with en-rise and byte-to-write latency checks.
        bus.ld_en = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.busy) break;
        end
        check("busy_rise_latency", lat, 4);
        check("cpu_hold_open", bus.cpu_hold, 1'b1);
        tick(2);
        send_bits(8'h01, 8);
        send_bits(8'h23, 8);
        expect_write(12'h123, 8'hA5);
        expect_write(12'h124, 8'h3C);
        expect_write(12'h125, 8'h7E);
        send_bits(8'h52, 7);
        bus.ld_sdi = 1'b1;
        tick(4);
        bus.ld_sck = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.mem_we) break;
        end
        check("we_latency", lat, 4);
        tick(1);
        bus.ld_sck = 1'b0;
        send_bits(8'h3C, 8);
        send_bits(8'h7E, 8);
        tick(4);
        bus.ld_en = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("busy_fall_latency", lat, 4);
        check("basic_cpu_hold", bus.cpu_hold, 1'b0);
        check("basic_wr_count", bus.wr_count, 12'd3);
        check("basic_err", bus.err, 1'b0);
        check("basic_last_addr", bus.mem_addr, 12'h125);
        tick(8);

        // Address wrap 0xFFF -> 0x000.
        open_session();
        send_bits(8'h0F, 8);
        send_bits(8'hFF, 8);
        expect_write(12'hFFF, 8'h11);
        expect_write(12'h000, 8'h22);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        close_session();
        check("wrap_wr_count", bus.wr_count, 12'd2);
        check("wrap_err", bus.err, 1'b0);

        // Abort mid data byte.
        open_session();
        send_bits(8'h00, 8);
        send_bits(8'h10, 8);
        expect_write(12'h010, 8'h55);
        send_bits(8'h55, 8);
        send_bits(8'h15, 5);
        close_session();
        check("abort_data_err", bus.err, 1'b1);
        check("abort_data_wr_count", bus.wr_count, 12'd1);
        check("abort_data_busy", bus.busy, 1'b0);

        // New session clears err, then abort inside the address header.
        open_session();
        check("restart_err_clear", bus.err, 1'b0);
        check("restart_wr_count_clear", bus.wr_count, 12'd0);
        send_bits(8'h05, 3);
        close_session();
        check("abort_hdr_err", bus.err, 1'b1);
        check("abort_hdr_busy", bus.busy, 1'b0);
        check("abort_hdr_wr_count", bus.wr_count, 12'd0);

        // Reset during the second data byte.
        open_session();
        send_bits(8'h02, 8);
        send_bits(8'h00, 8);
        expect_write(12'h200, 8'h99);
        send_bits(8'h99, 8);
        send_bits(8'h0A, 4);
        check("pre_rst_wr_count", bus.wr_count, 12'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_we", bus.mem_we, 1'b0);
        check("midrst_mem_addr", bus.mem_addr, 12'h000);
        check("midrst_mem_wdata", bus.mem_wdata, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_cpu_hold", bus.cpu_hold, 1'b0);
        check("midrst_err", bus.err, 1'b0);
        check("midrst_wr_count", bus.wr_count, 12'd0);
        rst = 1'b0;
        tick(6);
        send_bits(8'hFF, 8);
        send_bits(8'hAB, 8);
        tick(4);
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_wr_count", bus.wr_count, 12'd0);
        bus.ld_en = 1'b0;
        tick(8);

        // ena low across the 8th bit: that edge is dropped, the next one completes the byte.
        open_session();
        send_bits(8'h03, 8);
        send_bits(8'h40, 8);
        expect_write(12'h340, 8'h5A);
        send_bits(8'h5A, 8);
        send_bits(8'h61, 7);
        ena = 1'b0;
        send_bits(8'h01, 1);
        check("ena_low_mem_we", bus.mem_we, 1'b0);
        check("ena_low_wr_count", bus.wr_count, 12'd1);
        check("ena_low_busy", bus.busy, 1'b1);
        tick(4);
        ena = 1'b1;
        expect_write(12'h341, 8'hC2);
        send_bits(8'h00, 1);
        close_session();
        check("ena_wr_count", bus.wr_count, 12'd2);
        check("ena_err", bus.err, 1'b0);

        check("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that fills the 4096 x 8 program memory fetched by the microprocessor core's program counter. It is the write side of the program-memory interface: a host shifts a 12-bit start address followed by program bytes over a 3-wire synchronous serial link, and the block writes them sequentially into memory. While a load session is open it holds the CPU so that no fetch overlaps a write.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchronizer depth on serial inputs; legal range 2..3.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  clock enable; when low, all state and outputs hold (synchronizers still run).
- ld_sck  in  1  host serial clock, asynchronous to clk; data sampled on its rising edge.
- ld_sdi  in  1  host serial data, MSB first.
- ld_en  in  1  session enable, asynchronous; high = session open.
- mem_we  out  1  one-cycle write strobe to program memory.
- mem_addr  out  12  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  high while a session is open or a write is pending; the core freezes PC and phase.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky; set on an aborted partial byte or address header; cleared by rst or the next session start.
- wr_count  out  12  bytes written in the current or last session; wraps mod 4096.

## Operation
- All three serial inputs pass through SYNC_STAGES flops, then one edge-detect flop. `sck_rise` = synced ld_sck 0->1; `en_rise` and `en_fall` are defined likewise.
- Shift register: 8 bits with a 3-bit bit counter. On `sck_rise` with synced ld_en high, shift in synced ld_sdi. When the 8th bit arrives, assert `byte_rdy` for one cycle and clear the bit counter.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA.
  - IDLE -> ADDR_HI on `en_rise`. Clear bit counter, wr_count, err.
  - ADDR_HI: on `byte_rdy`, latch byte[3:0] into addr[11:8] (byte[7:4] ignored), then -> ADDR_LO.
  - ADDR_LO: on `byte_rdy`, latch addr[7:0], then -> DATA.
  - DATA: on `byte_rdy`, drive mem_wdata = byte and mem_addr = addr, and pulse mem_we for one cycle. Next cycle: addr = addr+1 mod 4096 (0xFFF -> 0x000, no error); wr_count +1 mod 4096.
  - Any state other than IDLE -> IDLE on `en_fall`. Set err if the bit counter is nonzero, or if the state is ADDR_HI or ADDR_LO with at least one bit received. A partial byte is discarded and never written.
- `en_rise` and `en_fall` in the same cycle cannot occur, because the edge detector sees a single sample.
- If `byte_rdy` and `en_fall` occur in the same cycle, the byte completes first: in DATA it is written, and the FSM then goes to IDLE with err clear.
- `sck_rise` while synced ld_en is low is ignored.
- cpu_hold = busy OR mem_we.
- mem_addr and mem_wdata hold their last written values when mem_we is low.

## Timing
- Reset values: mem_we=0, mem_addr=0x000, mem_wdata=0x00, cpu_hold=0, busy=0, err=0, wr_count=0x000. FSM=IDLE, bit counter=0, synchronizers=0.
- rst high mid-session: next edge forces the reset values; no write is issued; err stays 0.
- Latency from the ld_sck rising edge (8th data bit) to mem_we: SYNC_STAGES + 2 clk cycles (sync, edge detect, byte_rdy/write register). At SYNC_STAGES=2 this is 4 cycles.
- Latency from ld_en rising to busy=1: SYNC_STAGES + 2 cycles. From ld_en falling to busy=0: SYNC_STAGES + 2 cycles.
- Host constraint: ld_sck high and low phases each ≥ SYNC_STAGES+1 clk periods. ld_sdi stable ≥ SYNC_STAGES+1 cycles around the ld_sck rise. ld_en low ≥ SYNC_STAGES+1 cycles between sessions.
- mem_we is high for exactly one ena-qualified cycle per data byte. Back-to-back bytes produce no missed writes at the minimum sck period.

## Test plan
- Basic load: session with header 0x01,0x23, then data 0xA5,0x3C,0x7E, then ld_en low. Expect writes 0x123=A5, 0x124=3C, 0x125=7E; wr_count=3; err=0; cpu_hold falls to 0 after en_fall.
- Wrap: header 0x0F,0xFF, then data 0x11,0x22. Expect writes 0xFFF=11 and 0x000=22; err=0.
- Abort mid-byte: header 0x00,0x10, one full byte 0x55, then 5 bits, then ld_en low. Expect one write (0x010=55); no second mem_we; err=1. A new session start clears err.
- Abort in header: ld_en low after 3 bits of ADDR_HI. Expect no writes, err=1, busy=0.
- Reset mid-session: assert rst during the 2nd data byte. Expect all outputs at reset values on the next cycle and no mem_we. Sck edges after rst deasserts with ld_en still high are ignored until a new en_rise.
- ena gating: hold ena low across the 8th bit of a data byte. Expect no mem_we while ena=0. Counters and outputs are frozen; raising ena resumes shifting of subsequent edges.
